// File: rtl/dsp_mult_checker_if.sv
// Operand, DSP-result and status bundle between a DSP multiply path and its checker.
interface dsp_mult_checker_if #(
  parameter int unsigned A_WIDTH   = 20,
  parameter int unsigned B_WIDTH   = 18,
  parameter int unsigned Z_WIDTH   = 38,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 start_i;
  logic                 stop_i;
  logic                 valid_i;
  logic [A_WIDTH-1:0]   a_i;
  logic [B_WIDTH-1:0]   b_i;
  logic                 unsigned_a_i;
  logic                 unsigned_b_i;
  logic [Z_WIDTH-1:0]   z_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 error_o;
  logic                 mismatch_o;
  logic [Z_WIDTH-1:0]   expected_o;
  logic [CNT_WIDTH-1:0] check_count_o;
  logic [CNT_WIDTH-1:0] error_count_o;

  modport master (
    output start_i, stop_i, valid_i, a_i, b_i, unsigned_a_i, unsigned_b_i, z_i,
    input  busy_o, done_o, error_o, mismatch_o, expected_o, check_count_o, error_count_o
  );

  modport slave (
    input  start_i, stop_i, valid_i, a_i, b_i, unsigned_a_i, unsigned_b_i, z_i,
    output busy_o, done_o, error_o, mismatch_o, expected_o, check_count_o, error_count_o
  );
endinterface

// File: rtl/dsp_mult_checker.sv
// Response checker for a DSP multiply path: delays a locally computed product by the
// DSP latency, compares it against z, and counts checks and mismatches per run.
module dsp_mult_checker #(
  parameter int unsigned A_WIDTH    = 20,
  parameter int unsigned B_WIDTH    = 18,
  parameter int unsigned Z_WIDTH    = 38,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned MAX_CHECKS = 0
) (
  input  logic                clock_i,
  input  logic                reset_i,
  dsp_mult_checker_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [31:0]          acc_cnt_q, acc_cnt_d;
  logic [CNT_WIDTH-1:0] chk_cnt_q, chk_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [Z_WIDTH-1:0]   exp_hold_q, exp_hold_d;

  logic [Z_WIDTH-1:0]   a_ext, b_ext, product;
  logic                 limit_hit, accept, take;
  logic                 cmp_valid, cmp_en, mismatch, pipe_pending;
  logic [Z_WIDTH-1:0]   cmp_exp;

  always_comb begin
    a_ext   = {{(Z_WIDTH-A_WIDTH){bus.a_i[A_WIDTH-1] & ~bus.unsigned_a_i}}, bus.a_i};
    b_ext   = {{(Z_WIDTH-B_WIDTH){bus.b_i[B_WIDTH-1] & ~bus.unsigned_b_i}}, bus.b_i};
    product = a_ext * b_ext;
  end

  assign limit_hit = (MAX_CHECKS != 0) && (acc_cnt_q == MAX_CHECKS);
  assign accept    = (state_q == ST_RUN) && !limit_hit;
  assign take      = bus.valid_i & accept;

  generate
    if (LATENCY == 0) begin : g_comb
      assign cmp_valid    = take;
      assign cmp_exp      = product;
      assign pipe_pending = 1'b0;
    end else begin : g_pipe
      logic [LATENCY-1:0] vld_q, vld_d;
      logic [Z_WIDTH-1:0] exp_q [LATENCY];
      logic [Z_WIDTH-1:0] exp_d [LATENCY];

      always_comb begin
        vld_d[0] = take;
        exp_d[0] = product;
        for (int unsigned i = 1; i < LATENCY; i++) begin
          vld_d[i] = vld_q[i-1];
          exp_d[i] = exp_q[i-1];
        end
      end

      always_ff @(posedge clock_i) begin
        if (reset_i) begin
          vld_q <= '0;
          for (int unsigned i = 0; i < LATENCY; i++) exp_q[i] <= '0;
        end else begin
          vld_q <= vld_d;
          exp_q <= exp_d;
        end
      end

      assign cmp_valid = vld_q[LATENCY-1];
      assign cmp_exp   = exp_q[LATENCY-1];

      // Entries behind the output stage still owe a compare, so DRAIN must wait for them.
      if (LATENCY == 1) begin : g_one
        assign pipe_pending = 1'b0;
      end else begin : g_many
        assign pipe_pending = |vld_q[LATENCY-2:0];
      end
    end
  endgenerate

  assign cmp_en   = cmp_valid && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  // Case inequality so an X/Z on z_i is scored as a failure in 4-state simulation.
  assign mismatch = cmp_en && (bus.z_i !== cmp_exp);

  always_comb begin
    state_d    = state_q;
    acc_cnt_d  = acc_cnt_q + 32'(take);
    chk_cnt_d  = chk_cnt_q;
    err_cnt_d  = err_cnt_q;
    exp_hold_d = exp_hold_q;

    if (cmp_en) begin
      exp_hold_d = cmp_exp;
      if (chk_cnt_q != '1) chk_cnt_d = chk_cnt_q + CNT_WIDTH'(1);
      if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) begin
          state_d   = ST_RUN;
          acc_cnt_d = '0;
          chk_cnt_d = '0;
          err_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (bus.stop_i || ((MAX_CHECKS != 0) && (acc_cnt_d == MAX_CHECKS))) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pipe_pending) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_cnt_q  <= '0;
      chk_cnt_q  <= '0;
      err_cnt_q  <= '0;
      exp_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      acc_cnt_q  <= acc_cnt_d;
      chk_cnt_q  <= chk_cnt_d;
      err_cnt_q  <= err_cnt_d;
      exp_hold_q <= exp_hold_d;
    end
  end

  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.error_o       = done_q && (err_cnt_q != '0);
  assign bus.mismatch_o    = mismatch;
  assign bus.expected_o    = cmp_en ? cmp_exp : exp_hold_q;
  assign bus.check_count_o = chk_cnt_q;
  assign bus.error_count_o = err_cnt_q;

endmodule
